// File: rtl/nios_system_speed_sense.sv
// Avalon-MM wheel-speed sensor: counts synchronized encoder rising edges over a
// programmable gate window and publishes the count with a sticky done/irq.
module nios_system_speed_sense #(
  parameter int unsigned COUNT_W = 16,
  parameter int unsigned GATE_W  = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  input  logic        enc_in,
  output logic [31:0] readdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    ADDR_SPEED  = 2'd0,
    ADDR_GATE   = 2'd1,
    ADDR_CTRL   = 2'd2,
    ADDR_STATUS = 2'd3
  } addr_e;

  // Encoder input synchronizer and edge history.
  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  // Software-visible registers.
  logic [COUNT_W-1:0] speed_q, speed_d;
  logic [GATE_W-1:0]  gate_q, gate_d;
  logic               irq_en_q, irq_en_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;

  // Window measurement state.
  logic [GATE_W-1:0]  gate_cnt_q, gate_cnt_d;
  logic [COUNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic               win_ovf_q, win_ovf_d;

  logic               wr;
  logic               wr_gate;
  logic               wr_ctrl;
  logic               wr_status;
  logic               rise;
  logic               running;
  logic               win_end;
  logic               lost_pulse;
  logic [COUNT_W-1:0] pulse_next;
  logic               set_done;
  logic               set_ovf;
  logic               unused_wdata;

  assign wr        = chipselect & ~write_n;
  assign wr_gate   = wr && (addr_e'(address) == ADDR_GATE);
  assign wr_ctrl   = wr && (addr_e'(address) == ADDR_CTRL);
  assign wr_status = wr && (addr_e'(address) == ADDR_STATUS);

  assign rise    = s2_q & ~s3_q;
  assign running = (gate_q != '0);
  assign win_end = running && (gate_cnt_q == gate_q - GATE_W'(1));

  // A rise while the counter is already full is a lost pulse: count holds, window overflows.
  assign lost_pulse = rise & (&pulse_cnt_q);
  assign pulse_next = lost_pulse ? pulse_cnt_q : pulse_cnt_q + COUNT_W'(rise);

  assign unused_wdata = ^writedata;

  // NOTE: every signal gets a default at the top of the comb block so no path
  // leaves it unassigned; that is what keeps synthesis from inferring latches.
  always_comb begin
    s1_d        = enc_in;
    s2_d        = s1_q;
    s3_d        = s2_q;
    speed_d     = speed_q;
    gate_d      = gate_q;
    irq_en_d    = irq_en_q;
    done_d      = done_q;
    ovf_d       = ovf_q;
    gate_cnt_d  = gate_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    win_ovf_d   = win_ovf_q;
    set_done    = 1'b0;
    set_ovf     = 1'b0;

    // A GATE write restarts the window and swallows any window end on the same edge.
    if (wr_gate) begin
      gate_d      = writedata[GATE_W-1:0];
      gate_cnt_d  = '0;
      pulse_cnt_d = '0;
      win_ovf_d   = 1'b0;
    end else if (!running) begin
      gate_cnt_d  = '0;
      pulse_cnt_d = '0;
      win_ovf_d   = 1'b0;
    end else if (win_end) begin
      speed_d     = pulse_next;
      gate_cnt_d  = '0;
      pulse_cnt_d = '0;
      win_ovf_d   = 1'b0;
      set_done    = 1'b1;
      set_ovf     = win_ovf_q | lost_pulse;
    end else begin
      gate_cnt_d  = gate_cnt_q + GATE_W'(1);
      pulse_cnt_d = pulse_next;
      if (lost_pulse) begin
        win_ovf_d = 1'b1;
      end
    end

    if (wr_ctrl) begin
      irq_en_d = writedata[0];
    end

    // W1C first, set afterwards, so a set event on the same edge wins.
    if (wr_status && writedata[0]) begin
      done_d = 1'b0;
    end
    if (wr_status && writedata[1]) begin
      ovf_d = 1'b0;
    end
    if (set_done) begin
      done_d = 1'b1;
    end
    if (set_ovf) begin
      ovf_d = 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      speed_q     <= '0;
      gate_q      <= '0;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      gate_cnt_q  <= '0;
      pulse_cnt_q <= '0;
      win_ovf_q   <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      speed_q     <= speed_d;
      gate_q      <= gate_d;
      irq_en_q    <= irq_en_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      gate_cnt_q  <= gate_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      win_ovf_q   <= win_ovf_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (addr_e'(address))
      ADDR_SPEED:  readdata = 32'(speed_q);
      ADDR_GATE:   readdata = 32'(gate_q);
      ADDR_CTRL:   readdata = {31'd0, irq_en_q};
      ADDR_STATUS: readdata = {30'd0, ovf_q, done_q};
      default:     readdata = '0;
    endcase
  end

  assign irq = irq_en_q & done_q;

endmodule

// File: doc/nios_system_speed_sense.md
# nios_system_speed_sense

Avalon-MM slave peripheral that measures wheel speed from a single encoder pulse input and exposes the result to the Nios II. It counts synchronized rising edges of `enc_in` over a software-programmed gate window. At the end of each window it latches the count and raises a sticky done flag with an optional interrupt. It is the feedback counterpart of the drive-speed command output port and sits on the same system bus with the same register-access style.

## Interface

Parameters:
- `COUNT_W`, 16: width of pulse counter and speed result (1..31).
- `GATE_W`, 24: width of gate period register and gate counter (1..32).

Ports:
- `clk`  input  1  system clock; the only clock.
- `reset_n`  input  1  asynchronous, active-low reset.
- `address`  input  2  register select.
- `chipselect`  input  1  slave select.
- `write_n`  input  1  active-low write strobe; a write occurs when `chipselect && !write_n`.
- `writedata`  input  32  write data.
- `enc_in`  input  1  asynchronous encoder pulse.
- `readdata`  output  32  combinational read mux of `address`; unused bits 0.
- `irq`  output  1  level interrupt, `irq = irq_en & done`.

## Operation

Register map:
- addr 0 SPEED (RO): last completed window count, `COUNT_W` bits, zero-extended. Writes are ignored.
- addr 1 GATE (RW): gate period in clocks, `GATE_W` bits. A value of 0 disables measurement.
- addr 2 CTRL (RW): bit0 `irq_en`; other bits read 0.
- addr 3 STATUS (R/W1C): bit0 `done`, bit1 `ovf`. Writing 1 to a bit clears it.

Input path:
- `enc_in` passes through a two-flop synchronizer (`s1`, `s2`), then a history flop `s3`.
- `rise = s2 & ~s3`.

Measurement:
- Idle while GATE == 0: `gate_cnt` and `pulse_cnt` held at 0, SPEED holds its value, `done` is not set.
- Run while GATE != 0: `gate_cnt` increments every clock.
- On a `rise`, `pulse_cnt` increments and saturates at all-ones. Saturation sets an internal window-overflow bit.
- Window end is the cycle where `gate_cnt == GATE-1`. On that cycle:
  - SPEED is loaded with `pulse_cnt + rise`, saturated.
  - `gate_cnt` and `pulse_cnt` are cleared.
  - `done` is set.
  - `ovf` is set if the window saturated.
  - The window-overflow bit is cleared.
- GATE == 1: every clock is a window end, so SPEED = `rise`.
- A write to GATE clears `gate_cnt`, `pulse_cnt` and the window-overflow bit on the same edge. The new window starts on the next cycle. A window end coinciding with a GATE write is discarded: no SPEED update, no `done`.
- If a STATUS W1C and a set event land on the same edge, the set wins.
- The register writes above require `chipselect && !write_n` with the matching address. Other addresses have no side effects. Reads never have side effects.

Reset values: SPEED 0, GATE 0, `irq_en` 0, `done` 0, `ovf` 0, counters 0, `s1`/`s2`/`s3` 0, `irq` 0.

## Timing

- An `enc_in` rise first sampled at clock edge N gives `rise` high in cycle N+1. `pulse_cnt` updates at edge N+2.
- `enc_in` must be stable high for ≥2 clocks and low for ≥2 clocks to count exactly once. Shorter pulses may be missed; they are never double-counted.
- With GATE = G, a window is exactly G clocks. Windows repeat back-to-back with no dead cycle.
- SPEED, `done` and `irq` change on the edge that ends the window. `irq` is registered-derived with zero extra latency from `done`/`irq_en`.
- Register writes take effect on the edge where the write is sampled. `readdata` reflects the new value in the following cycle.
- `reset_n` assertion mid-window immediately clears all state asynchronously. After release, measurement stays idle until GATE is written.

## Test plan

- Reset → all four registers read 0, `irq` = 0. Write GATE = 100, then 10 pulses (4 high / 4 low) inside one window → SPEED = 10, STATUS = 0x1 at the window end.
- CTRL = 1 with `done` set → `irq` = 1. Write STATUS = 0x1 → `irq` = 0 next cycle. The next window end sets `irq` again. A W1C on the same edge as a window end leaves `done` = 1.
- `COUNT_W` = 4, GATE = 200, 20 pulses → SPEED = 15, STATUS = 0x3. The following window with 3 pulses → SPEED = 3, `ovf` remains 1 until cleared.
- 1-clock-wide glitches on `enc_in` → each counts at most once. A 4-clock pulse whose `rise` lands on the final window cycle → counted in that window's SPEED.
- Rewrite GATE = 50 mid-window → no SPEED update for the aborted window, first `done` exactly 50 clocks after the write. GATE = 0 → `done` is never set again.
- Assert `reset_n` mid-window with counts pending → SPEED/STATUS read 0 after release, no `irq`.
